// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: word width and lane packing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sa_pkg;

    // Width of one row word travelling into the array's west edge.
    localparam int DATA_W = 9;

    // Bit offset of lane `lane` inside a flat lane-packed bus (lane 0 at LSBs).
    function automatic int lane_lsb(input int lane);
        return lane * DATA_W;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register of {valid,data}; DEPTH=0 is a plain wire.
// Latency: exactly DEPTH cycles from i_vld/i_dat to o_vld/o_dat.
// Backpressure: none; shifts every cycle, so it holds at most DEPTH entries in flight.
module skew_delay_line #(
    parameter int DEPTH = 0,
    parameter int W     = 9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_pass
            // No storage: clock and reset are intentionally left unused here.
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_vld    = i_vld;
            assign o_dat    = i_dat;
        end else begin : g_shift
            logic [DEPTH-1:0] r_vld;
            logic [W-1:0]     r_dat [DEPTH];

            // Shift valid and data together; reset flushes anything in flight.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_vld <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_dat[i] <= '0;
                    end
                end else begin
                    r_vld[0] <= i_vld;
                    r_dat[0] <= i_dat;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end

            assign o_vld = r_vld[DEPTH-1];
            assign o_dat = r_dat[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/row_skew_feeder.sv
// Gathers serialized row words into a ROW-wide vector and launches it through a triangular skew.
// Latency: lane k valid for the cycle after edge T+1+k, where T is the edge accepting the last word/flush.
// Backpressure: none; every i_wren word is accepted and launches may occur every cycle.
module row_skew_feeder
    import sa_pkg::*;
#(
    parameter int ROW = 9
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_wren,
    input  logic                       i_flush,
    output logic [DATA_W*ROW-1:0]      o_data,
    output logic [ROW-1:0]             o_valid,
    output logic                       o_vec_done,
    output logic [$clog2(ROW+1)-1:0]   o_fill
);

    localparam int                FILL_W   = $clog2(ROW + 1);
    localparam logic [FILL_W-1:0] LAST_IDX = FILL_W'(ROW - 1);

    logic [FILL_W-1:0]       r_idx;
    logic [DATA_W-1:0]       r_gbuf [ROW];
    logic                    r_launch;
    logic                    w_launch;

    logic [ROW-1:0]          w_lane_vld;
    logic [DATA_W-1:0]       w_lane_dat [ROW];
    logic [ROW-1:0]          r_o_vld;
    logic [DATA_W*ROW-1:0]   r_o_dat;

    // Launch when the vector completes, or on a flush that has (or is adding) at least one word.
    always_comb begin
        w_launch = 1'b0;
        if (i_wren) begin
            w_launch = (r_idx == LAST_IDX) || i_flush;
        end else begin
            w_launch = i_flush && (r_idx != '0);
        end
    end

    // Gather buffer, write index and launch strobe; the buffer clears the cycle after a launch
    // unless a new word lands in that slot on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx    <= '0;
            r_launch <= 1'b0;
            for (int k = 0; k < ROW; k++) begin
                r_gbuf[k] <= '0;
            end
        end else begin
            r_launch <= w_launch;
            if (w_launch) begin
                r_idx <= '0;
            end else if (i_wren) begin
                r_idx <= r_idx + 1'b1;
            end
            for (int k = 0; k < ROW; k++) begin
                if (i_wren && (r_idx == FILL_W'(k))) begin
                    r_gbuf[k] <= i_data;
                end else if (r_launch) begin
                    r_gbuf[k] <= '0;
                end
            end
        end
    end

    // Lane k waits k extra cycles so the array sees a diagonal wavefront.
    generate
        for (genvar k = 0; k < ROW; k++) begin : g_lane
            skew_delay_line #(
                .DEPTH (k),
                .W     (DATA_W)
            ) u_skew (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_vld (r_launch),
                .i_dat (r_gbuf[k]),
                .o_vld (w_lane_vld[k]),
                .o_dat (w_lane_dat[k])
            );
        end
    endgenerate

    // Output stage: valid is a one-cycle pulse per lane, data holds its last value when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_o_vld <= '0;
            r_o_dat <= '0;
        end else begin
            r_o_vld <= w_lane_vld;
            for (int k = 0; k < ROW; k++) begin
                if (w_lane_vld[k]) begin
                    r_o_dat[lane_lsb(k) +: DATA_W] <= w_lane_dat[k];
                end
            end
        end
    end

    assign o_data     = r_o_dat;
    assign o_valid    = r_o_vld;
    assign o_vec_done = r_o_vld[ROW-1];
    assign o_fill     = r_idx;

endmodule
